// File: rtl/ud_count_decoder.sv
// ud_count_decoder
//   Receive-side observer for an up/down counter. It samples the count bus on
//   count_vld and classifies each step against the previous sample. From that
//   it recovers the counting direction and the programmed limit, pulses wrap on
//   wrap/reload events, pulses err on impossible steps, and tracks lock state.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   count_vld  in   sample strobe
//   count      in   observed counter value [WIDTH-1:0]
//   dir        out  recovered direction (0 = up, 1 = down)
//   dir_vld    out  dir has been determined at least once
//   limit      out  recovered count limit [WIDTH-1:0]
//   limit_vld  out  limit is current
//   wrap       out  one-cycle pulse on wrap or reload
//   err        out  one-cycle pulse on an illegal step
//   locked     out  high in the LOCKED state
//   err_cnt    out  saturating error count [7:0]
module ud_count_decoder #(
   parameter int WIDTH    = 3,
   parameter int LOCK_CNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             count_vld,
   input  logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             dir_vld,
   output logic [WIDTH-1:0] limit,
   output logic             limit_vld,
   output logic             wrap,
   output logic             err,
   output logic             locked,
   output logic [7:0]       err_cnt
);

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] ACQ    = 2'b01;
   localparam logic [1:0] LOCKED = 2'b10;

   localparam logic [WIDTH-1:0] ZERO_C     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C      = WIDTH'(1);
   localparam logic [WIDTH:0]   ONE_X      = (WIDTH+1)'(1);
   localparam logic [3:0]       LOCK_CNT_C = 4'(LOCK_CNT);

   // Saturating increment of the 8-bit error counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      if (val == 8'hFF) begin
         return val;
      end else begin
         return val + 8'd1;
      end
   endfunction

   logic [1:0]       state_r,     state_s;
   logic [3:0]       lock_cnt_r,  lock_cnt_s;
   logic [WIDTH-1:0] prev_r,      prev_s;
   logic             dir_r,       dir_s;
   logic             dir_vld_r,   dir_vld_s;
   logic [WIDTH-1:0] limit_r,     limit_s;
   logic             limit_vld_r, limit_vld_s;
   logic             wrap_r,      wrap_s;
   logic             err_r,       err_s;
   logic [7:0]       err_cnt_r,   err_cnt_s;

   // Steps are compared one bit wider so p+1 / p-1 never wrap modulo 2^WIDTH.
   logic [WIDTH:0] p_ext_s, c_ext_s, p_inc_s, p_dec_s;
   logic           step_err_s;

   assign p_ext_s = {1'b0, prev_r};
   assign c_ext_s = {1'b0, count};
   assign p_inc_s = p_ext_s + ONE_X;
   assign p_dec_s = p_ext_s - ONE_X;

   // Next-state: step classification (first matching rule wins) and FSM.
   always_comb begin
      state_s     = state_r;
      lock_cnt_s  = lock_cnt_r;
      prev_s      = prev_r;
      dir_s       = dir_r;
      dir_vld_s   = dir_vld_r;
      limit_s     = limit_r;
      limit_vld_s = limit_vld_r;
      wrap_s      = 1'b0;
      err_s       = 1'b0;
      err_cnt_s   = err_cnt_r;
      step_err_s  = 1'b0;

      if (count_vld) begin
         prev_s = count;
         if (state_r == IDLE) begin
            state_s = ACQ;
         end else begin
            if (count == prev_r) begin
               step_err_s = 1'b1;
            end else if ((prev_r == ZERO_C) && (count == ONE_C)) begin
               // 0->1 is ambiguous: down-wrap with limit 1 when already counting down.
               if (dir_vld_r && dir_r) begin
                  limit_s     = ONE_C;
                  limit_vld_s = 1'b1;
                  wrap_s      = 1'b1;
               end else begin
                  dir_s     = 1'b0;
                  dir_vld_s = 1'b1;
               end
            end else if ((prev_r == ONE_C) && (count == ZERO_C)) begin
               // 1->0 mirrors the above: up-wrap with limit 1 when counting up.
               if (dir_vld_r && !dir_r) begin
                  limit_s     = ONE_C;
                  limit_vld_s = 1'b1;
                  wrap_s      = 1'b1;
               end else begin
                  dir_s     = 1'b1;
                  dir_vld_s = 1'b1;
               end
            end else if (c_ext_s == p_inc_s) begin
               dir_s     = 1'b0;
               dir_vld_s = 1'b1;
               // Counting above the known limit means the limit was reprogrammed.
               if (limit_vld_r && (count > limit_r)) begin
                  limit_vld_s = 1'b0;
               end else begin
                  limit_vld_s = limit_vld_r;
               end
            end else if ((prev_r != ZERO_C) && (c_ext_s == p_dec_s)) begin
               dir_s     = 1'b1;
               dir_vld_s = 1'b1;
            end else if (count == ZERO_C) begin
               // p > 1 here. While counting down this is a counter reset, not a wrap.
               if (!dir_r || !dir_vld_r) begin
                  limit_s     = prev_r;
                  limit_vld_s = 1'b1;
                  wrap_s      = 1'b1;
               end else begin
                  limit_s = limit_r;
               end
            end else if (prev_r == ZERO_C) begin
               // c > 1 here: down-wrap reveals the limit.
               limit_s     = count;
               limit_vld_s = 1'b1;
               dir_s       = 1'b1;
               dir_vld_s   = 1'b1;
               wrap_s      = 1'b1;
            end else if (c_ext_s < p_dec_s) begin
               // Down-reload after the limit was lowered below the current count.
               limit_s     = count;
               limit_vld_s = 1'b1;
               dir_s       = 1'b1;
               dir_vld_s   = 1'b1;
               wrap_s      = 1'b1;
            end else begin
               step_err_s = 1'b1;
            end

            if (step_err_s) begin
               err_s      = 1'b1;
               state_s    = ACQ;
               lock_cnt_s = 4'd0;
               err_cnt_s  = sat_inc8(err_cnt_r);
            end else begin
               case (state_r)
                  ACQ: begin
                     lock_cnt_s = lock_cnt_r + 4'd1;
                     if ((lock_cnt_r + 4'd1) >= LOCK_CNT_C) begin
                        state_s = LOCKED;
                     end else begin
                        state_s = ACQ;
                     end
                  end
                  LOCKED: begin
                     state_s = LOCKED;
                  end
                  default: begin
                     state_s    = IDLE;
                     lock_cnt_s = 4'd0;
                  end
               endcase
            end
         end
      end else begin
         prev_s = prev_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         lock_cnt_r  <= 4'd0;
         prev_r      <= ZERO_C;
         dir_r       <= 1'b0;
         dir_vld_r   <= 1'b0;
         limit_r     <= ZERO_C;
         limit_vld_r <= 1'b0;
         wrap_r      <= 1'b0;
         err_r       <= 1'b0;
         err_cnt_r   <= 8'd0;
      end else begin
         state_r     <= state_s;
         lock_cnt_r  <= lock_cnt_s;
         prev_r      <= prev_s;
         dir_r       <= dir_s;
         dir_vld_r   <= dir_vld_s;
         limit_r     <= limit_s;
         limit_vld_r <= limit_vld_s;
         wrap_r      <= wrap_s;
         err_r       <= err_s;
         err_cnt_r   <= err_cnt_s;
      end
   end

   assign dir       = dir_r;
   assign dir_vld   = dir_vld_r;
   assign limit     = limit_r;
   assign limit_vld = limit_vld_r;
   assign wrap      = wrap_r;
   assign err       = err_r;
   assign locked    = (state_r == LOCKED);
   assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_ud_count_decoder.sv
// tb_ud_count_decoder
//   Table-driven bench for ud_count_decoder. Each row is either a reset or a
//   sample plus the outputs expected after the following rising edge. Expected
//   values go into a scoreboard queue when the row is driven and are popped
//   and compared once the DUT output is settled.
module tb_ud_count_decoder;

   logic       clk;
   logic       rst_n;
   logic       count_vld;
   logic [2:0] count;
   logic       dir, dir_vld, limit_vld, wrap, err, locked;
   logic [2:0] limit;
   logic [7:0] err_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit         rst;
      bit         vld;
      logic [2:0] cnt;
      logic [16:0] exp;  // {dir, dir_vld, limit, limit_vld, wrap, err, locked, err_cnt}
      string      tag;
   } vec_t;

   vec_t        vecs[$];
   logic [16:0] sb_q[$];

   ud_count_decoder #(.WIDTH(3), .LOCK_CNT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .count_vld (count_vld),
      .count     (count),
      .dir       (dir),
      .dir_vld   (dir_vld),
      .limit     (limit),
      .limit_vld (limit_vld),
      .wrap      (wrap),
      .err       (err),
      .locked    (locked),
      .err_cnt   (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   task automatic add(input string tag, input bit rst, input bit vld, input logic [2:0] c,
                      input bit d, input bit dv, input logic [2:0] lim, input bit lv,
                      input bit w, input bit e, input bit lk, input logic [7:0] ec);
      vec_t v;
      v.rst = rst;
      v.vld = vld;
      v.cnt = c;
      v.exp = {d, dv, lim, lv, w, e, lk, ec};
      v.tag = tag;
      vecs.push_back(v);
   endtask

   task automatic compare(input string tag);
      logic [16:0] exp_v;
      logic [16:0] act_v;
      act_v = {dir, dir_vld, limit, limit_vld, wrap, err, locked, err_cnt};
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s: scoreboard empty, got=%h", tag, act_v);
      end else begin
         exp_v = sb_q.pop_front();
         if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got dir=%b dv=%b lim=%0d lv=%b wrap=%b err=%b lock=%b ecnt=%0d required dir=%b dv=%b lim=%0d lv=%b wrap=%b err=%b lock=%b ecnt=%0d",
                     tag, act_v[16], act_v[15], act_v[14:12], act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                     exp_v[16], exp_v[15], exp_v[14:12], exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
         end
      end
   endtask

   // Entered and left on a falling clock edge.
   task automatic drive(input vec_t v);
      if (v.rst) begin
         count_vld = 1'b0;
         count     = 3'd0;
         #2 rst_n  = 1'b0;
         sb_q.push_back(v.exp);
         #1 compare(v.tag);
         @(negedge clk);
         rst_n = 1'b1;
      end else begin
         count_vld = v.vld;
         count     = v.cnt;
         sb_q.push_back(v.exp);
         @(posedge clk);
         #1 compare(v.tag);
         @(negedge clk);
      end
   endtask

   task automatic run_table();
      foreach (vecs[i]) drive(vecs[i]);
      vecs.delete();
   endtask

   initial begin
      vec_t rv;
      rst_n     = 1'b0;
      count_vld = 1'b0;
      count     = 3'd0;
      @(negedge clk);

      //     tag        rst vld cnt  dir dv lim lv w  e  lk ecnt
      // Up-count, limit 5
      add("A_rst",  1, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("A_s0",   0, 1, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("A_s1",   0, 1, 3'd1, 0, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("A_s2",   0, 1, 3'd2, 0, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("A_s3",   0, 1, 3'd3, 0, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("A_s4",   0, 1, 3'd4, 0, 1, 3'd0, 0, 0, 0, 1, 8'd0);
      add("A_s5",   0, 1, 3'd5, 0, 1, 3'd0, 0, 0, 0, 1, 8'd0);
      add("A_wrap", 0, 1, 3'd0, 0, 1, 3'd5, 1, 1, 0, 1, 8'd0);
      add("A_s1b",  0, 1, 3'd1, 0, 1, 3'd5, 1, 0, 0, 1, 8'd0);
      add("A_hold", 0, 0, 3'd3, 0, 1, 3'd5, 1, 0, 0, 1, 8'd0);
      // Down-count, limit 6
      add("B_rst",  1, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("B_s3",   0, 1, 3'd3, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("B_s2",   0, 1, 3'd2, 1, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("B_s1",   0, 1, 3'd1, 1, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("B_s0",   0, 1, 3'd0, 1, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("B_wrap", 0, 1, 3'd6, 1, 1, 3'd6, 1, 1, 0, 1, 8'd0);
      add("B_s5",   0, 1, 3'd5, 1, 1, 3'd6, 1, 0, 0, 1, 8'd0);
      // Mode flip
      add("C_rst",  1, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("C_s0",   0, 1, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("C_s1",   0, 1, 3'd1, 0, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("C_s2",   0, 1, 3'd2, 0, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("C_s3",   0, 1, 3'd3, 0, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("C_flip", 0, 1, 3'd2, 1, 1, 3'd0, 0, 0, 0, 1, 8'd0);
      add("C_s1b",  0, 1, 3'd1, 1, 1, 3'd0, 0, 0, 0, 1, 8'd0);
      // Illegal jump and relock
      add("D_rst",  1, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("D_s0",   0, 1, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("D_s1",   0, 1, 3'd1, 0, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("D_s2",   0, 1, 3'd2, 0, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("D_s3",   0, 1, 3'd3, 0, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("D_s4",   0, 1, 3'd4, 0, 1, 3'd0, 0, 0, 0, 1, 8'd0);
      add("D_jump", 0, 1, 3'd7, 0, 1, 3'd0, 0, 0, 1, 0, 8'd1);
      add("D_s6",   0, 1, 3'd6, 1, 1, 3'd0, 0, 0, 0, 0, 8'd1);
      add("D_s5",   0, 1, 3'd5, 1, 1, 3'd0, 0, 0, 0, 0, 8'd1);
      add("D_s4b",  0, 1, 3'd4, 1, 1, 3'd0, 0, 0, 0, 0, 8'd1);
      add("D_relk", 0, 1, 3'd3, 1, 1, 3'd0, 0, 0, 0, 1, 8'd1);
      // Limit-1 ambiguity
      add("E_rst",  1, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("E_s5",   0, 1, 3'd5, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("E_s4",   0, 1, 3'd4, 1, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("E_rl1",  0, 1, 3'd1, 1, 1, 3'd1, 1, 1, 0, 0, 8'd0);
      add("E_s0",   0, 1, 3'd0, 1, 1, 3'd1, 1, 0, 0, 0, 8'd0);
      add("E_dw1",  0, 1, 3'd1, 1, 1, 3'd1, 1, 1, 0, 1, 8'd0);
      // Down-reload from 6 to 3, then lock
      add("F_rst",  1, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("F_s7",   0, 1, 3'd7, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("F_s6",   0, 1, 3'd6, 1, 1, 3'd0, 0, 0, 0, 0, 8'd0);
      add("F_rl3",  0, 1, 3'd3, 1, 1, 3'd3, 1, 1, 0, 0, 8'd0);
      add("F_s2",   0, 1, 3'd2, 1, 1, 3'd3, 1, 0, 0, 0, 8'd0);
      add("F_s1",   0, 1, 3'd1, 1, 1, 3'd3, 1, 0, 0, 1, 8'd0);
      run_table();

      // Asynchronous reset while locked: outputs clear with no clock edge.
      count_vld = 1'b0;
      #2 rst_n  = 1'b0;
      rv.exp = 17'd0;
      sb_q.push_back(rv.exp);
      #1 compare("G_async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Stall detection and err_cnt saturation.
      add("H_s2",   0, 1, 3'd2, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0);
      add("H_stl1", 0, 1, 3'd2, 0, 0, 3'd0, 0, 0, 1, 0, 8'd1);
      add("H_idle", 0, 0, 3'd2, 0, 0, 3'd0, 0, 0, 0, 0, 8'd1);
      for (int k = 2; k <= 260; k++) begin
         add($sformatf("H_stl%0d", k), 0, 1, 3'd2, 0, 0, 3'd0, 0, 0, 1, 0,
             (k > 255) ? 8'd255 : 8'(k));
      end
      run_table();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ud_count_decoder.md
Name: ud_count_decoder

Overview:
- Receive-side observer for the 3-bit up/down counter's count output.
- Samples the count value on a strobe and classifies each step against the previous sample.
- Recovers the counting direction and the programmed count limit, pulses on wrap-around, and flags impossible sequences.
- Sits beside the counter in the HW3 datapath; the bench also uses it as an online checker.

Parameters:
- WIDTH, 3, width of the observed count bus.
- LOCK_CNT, 4, consecutive legal samples required to enter LOCKED (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- count_vld  input  1  sample strobe; count is sampled only when high.
- count  input  WIDTH  observed counter value.
- dir  output  1  recovered direction: 0 = up, 1 = down.
- dir_vld  output  1  dir has been determined at least once.
- limit  output  WIDTH  recovered count limit.
- limit_vld  output  1  limit is current.
- wrap  output  1  one-cycle pulse on a wrap or reload event.
- err  output  1  one-cycle pulse on an illegal step.
- locked  output  1  high in the LOCKED state.
- err_cnt  output  8  saturating error count (stops at 255).

Behaviour:
- Reset state: all outputs 0, state IDLE, prev register 0, lock counter 0.
- Timing: all outputs are registered; a sample taken on edge N drives outputs after edge N. wrap and err are high for exactly one cycle per sample. When count_vld=0, all state holds and wrap/err are 0.
- States:
  - IDLE: the first sample loads prev, moves to ACQ, and raises no flags.
  - ACQ: every legal sample increments the lock counter; reaching LOCK_CNT moves to LOCKED.
  - LOCKED: legal samples hold the state.
  - From ACQ or LOCKED, an err sample moves to ACQ, clears the lock counter and increments err_cnt.
- Step classification uses p = prev and c = count. Rules are evaluated in priority order; the first match wins:
  1. c == p: stall, err.
  2. p == 0, c == 1: if dir_vld and dir = 1, treat as a down-wrap with limit = 1. Otherwise treat as an up-step: dir <= 0, dir_vld <= 1.
  3. p == 1, c == 0: if dir_vld and dir = 0, treat as an up-wrap with limit = 1. Otherwise treat as a down-step: dir <= 1, dir_vld <= 1.
  4. c == p+1 (no modular wrap): up-step. Set dir <= 0. If limit_vld and c > limit, clear limit_vld (limit is stale).
  5. c == p-1: down-step, dir <= 1.
  6. c == 0, p > 1: if dir = 0 or !dir_vld, up-wrap: limit <= p, limit_vld <= 1, wrap. If dir = 1, treat as a counter reset: no wrap, limit unchanged.
  7. p == 0, c > 1: down-wrap: limit <= c, limit_vld <= 1, dir <= 1, dir_vld <= 1, wrap.
  8. 0 < c < p-1: down-reload (limit lowered while the counter was out of range): limit <= c, limit_vld <= 1, dir <= 1, wrap.
  9. c > p+1, p != 0: illegal, err. dir and limit are unchanged.
- Every sample updates prev <= c, including err samples.
- Direction reversal through rule 4 or 5 is legal and raises no err.
- If a reset asserts mid-sequence, the block returns to IDLE immediately and err_cnt clears.

Test Plan:
- Up-count limit 5: reset, then count_vld=1 every cycle with count 0,1,2,3,4,5,0,1. Required: dir=0 and dir_vld=1 after the 2nd sample; wrap pulses exactly once (cycle after the 0 following 5); limit=5, limit_vld=1; locked after sample 5; err never set.
- Down-count limit 6: samples 3,2,1,0,6,5. Required: dir=1; wrap on the 6; limit=6; err=0.
- Mode flip: samples 0,1,2,3,2,1. Required: dir goes 0 to 1 after the 3→2 sample; no err; locked stays high once reached.
- Illegal jump: lock on 0,1,2,3,4, then sample 7. Required: err pulses one cycle; err_cnt=1; locked drops; state ACQ; relock after 4 further legal samples.
- Limit-1 ambiguity and reload: with dir=1 (from 5,4), sample 1,0,1. Required: the 0→1 step is a down-wrap, limit=1, wrap=1. Separately, with dir=1 and prev=6, sample 3: down-reload, limit=3, wrap=1.
- Async reset and stall: assert rst_n low mid-cycle while locked. Required: outputs 0 without waiting for a clock edge. After release, samples 2,2: err=1 on the second 2; err_cnt saturates at 255 under continuous stalls.
